// File: rtl/dual_req_unit_arbiter_pkg.sv
// Shared types for the two-requester arbiter in front of the fixed-latency arithmetic unit.
// Word width, owner index and the {valid, owner} tag that travels alongside each issued operand.
package dual_req_unit_arbiter_pkg;

    localparam int INT_LENGTH_DEF  = 5;
    localparam int FRAC_LENGTH_DEF = 12;
    localparam int W               = INT_LENGTH_DEF + FRAC_LENGTH_DEF;

    typedef logic owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

endpackage

// File: rtl/dual_req_unit_arbiter_tag_pipe.sv
// arb_tag_pipe: UNIT_LAT-deep shift register of issue tags.
// Its last stage lines up with the shared unit's res_valid.
module arb_tag_pipe
    import dual_req_unit_arbiter_pkg::*;
#(
    parameter int UNIT_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [UNIT_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < UNIT_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < UNIT_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[UNIT_LAT-1];

endmodule

// File: rtl/dual_req_unit_arbiter.sv
// Round-robin sharing of one fixed-latency arithmetic unit between two requesters, with result routing.
// Define ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of alternating.
module dual_req_unit_arbiter
    import dual_req_unit_arbiter_pkg::*;
#(
    parameter int INT_LENGTH  = INT_LENGTH_DEF,
    parameter int FRAC_LENGTH = FRAC_LENGTH_DEF,
    parameter int UNIT_LAT    = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req0_valid,
    input  logic [INT_LENGTH+FRAC_LENGTH-1:0] req0_data,
    output logic                              req0_ready,
    input  logic                              req1_valid,
    input  logic [INT_LENGTH+FRAC_LENGTH-1:0] req1_data,
    output logic                              req1_ready,
    output logic                              op_valid,
    output logic                              op_sel,
    output logic [INT_LENGTH+FRAC_LENGTH-1:0] op_data,
    input  logic                              res_valid,
    input  logic [INT_LENGTH+FRAC_LENGTH-1:0] res_data,
    output logic                              rsp0_valid,
    output logic                              rsp1_valid,
    output logic [INT_LENGTH+FRAC_LENGTH-1:0] rsp_data,
    output logic                              tag_err
);

    logic grant0;
    logic grant1;
    logic xfer;
    tag_t tag_in;
    tag_t tag_out;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`else
    owner_t last_grant;

    // On a tie the requester that did not win last time gets the unit.
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last_grant <= 1'b1;
        else if (xfer) last_grant <= grant1;
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 || grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_sel   <= 1'b0;
            op_data  <= '0;
        end else begin
            op_valid <= xfer;
            if (xfer) begin
                op_sel  <= grant1;
                op_data <= grant1 ? req1_data : req0_data;
            end
        end
    end

    assign tag_in = '{valid: op_valid, owner: op_sel};

    arb_tag_pipe #(
        .UNIT_LAT (UNIT_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // A result without a tag, or a tag without a result, means the unit and the pipe lost step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
            tag_err    <= 1'b0;
        end else begin
            rsp0_valid <= res_valid && tag_out.valid && (tag_out.owner == 1'b0);
            rsp1_valid <= res_valid && tag_out.valid && (tag_out.owner == 1'b1);
            rsp_data   <= res_data;
            tag_err    <= tag_err || (res_valid != tag_out.valid);
        end
    end

endmodule

// File: tb/tb_dual_req_unit_arbiter.sv
// Bench for dual_req_unit_arbiter: per-cycle expectation tables built from the arbitration and latency rules.
// The shared unit is modelled as a UNIT_LAT-cycle identity delay line.
module tb_dual_req_unit_arbiter;
    import dual_req_unit_arbiter_pkg::*;

    localparam int L  = 4;
    localparam int NC = 2048;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_data, req1_data;
    logic         op_valid, op_sel;
    logic [W-1:0] op_data;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         rsp0_valid, rsp1_valid, tag_err;
    logic [W-1:0] rsp_data;

    dual_req_unit_arbiter #(.INT_LENGTH(5), .FRAC_LENGTH(12), .UNIT_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .op_valid(op_valid), .op_sel(op_sel), .op_data(op_data),
        .res_valid(res_valid), .res_data(res_data),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    // Expected registered outputs indexed by cycle number.
    bit         m_opv [NC];
    bit         m_ops [NC];
    bit [W-1:0] m_opd [NC];
    bit         m_r0  [NC];
    bit         m_r1  [NC];
    bit [W-1:0] m_rd  [NC];
    bit         m_err [NC];
    bit         m_last;
    // Shared unit history (what it was handed at each cycle).
    bit         u_v   [NC];
    bit [W-1:0] u_d   [NC];

    int cyc;
    int n_total;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_sel", op_sel, 0);
        chk("rst_op_data", op_data, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_rsp1", rsp1_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
    endtask

    // One clock cycle: check registered outputs, drive inputs, check grants, extend the model.
    task automatic cycle(input bit v0, input logic [W-1:0] d0,
                         input bit v1, input logic [W-1:0] d1, input bit inj);
        bit         g0, g1, rv, tv, to;
        logic [W-1:0] rd;
        chk("op_valid", op_valid, m_opv[cyc]);
        chk("op_sel", op_sel, m_ops[cyc]);
        chk("op_data", op_data, m_opd[cyc]);
        chk("rsp0_valid", rsp0_valid, m_r0[cyc]);
        chk("rsp1_valid", rsp1_valid, m_r1[cyc]);
        if (m_r0[cyc] || m_r1[cyc]) chk("rsp_data", rsp_data, m_rd[cyc]);
        chk("tag_err", tag_err, m_err[cyc]);

        u_v[cyc] = op_valid;
        u_d[cyc] = op_data;
        rv = u_v[cyc-L];
        rd = u_d[cyc-L];
        if (inj) begin
            rv = 1'b1;
            rd = W'($urandom);
        end
        res_valid  = rv;
        res_data   = rd;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        #1;
`ifdef ARB_FIXED_PRIO_EN
        g0 = v0;
        g1 = v1 && !v0;
`else
        g0 = v0 && (!v1 || m_last);
        g1 = v1 && (!v0 || !m_last);
`endif
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);

        m_opv[cyc+1] = g0 || g1;
        m_ops[cyc+1] = g1 ? 1'b1 : (g0 ? 1'b0 : m_ops[cyc]);
        m_opd[cyc+1] = g1 ? d1 : (g0 ? d0 : m_opd[cyc]);
        if (g0 || g1) m_last = g1;
        tv = m_opv[cyc-L];
        to = m_ops[cyc-L];
        m_r0[cyc+1]  = rv && tv && !to;
        m_r1[cyc+1]  = rv && tv && to;
        m_rd[cyc+1]  = rd;
        m_err[cyc+1] = m_err[cyc] || (rv != tv);

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk_all_zero();
        u_v[cyc] = 1'b0;
        u_d[cyc] = '0;
        res_valid = u_v[cyc-L];
        res_data  = u_d[cyc-L];
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        for (int j = 0; j <= cyc; j++) begin
            m_opv[j] = 0; m_ops[j] = 0; m_opd[j] = '0;
            m_r0[j] = 0; m_r1[j] = 0; m_rd[j] = '0; m_err[j] = 0;
        end
        m_last = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        cyc     = 8;
        m_last  = 1'b1;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
        res_valid = 0; res_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero();
        rst_n = 1'b1;

        // Lone requester 0.
        cycle(1, 17'h00800, 0, '0, 0);
        idle(8);

        // Both requesters valid for six cycles.
        for (int i = 0; i < 6; i++) cycle(1, W'(17'h01000 + i), 1, W'(17'h02000 + i), 0);
        idle(8);

        // Requester 1 held, requester 0 toggling.
        for (int i = 0; i < 10; i++) cycle(i % 2 == 0, W'(17'h03000 + i), 1, W'(17'h04000 + i), 0);
        idle(8);

        // Random traffic, data churning while stalled.
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 1) == 1, W'($urandom), 0);
        idle(8);

        // Result with no tag behind it.
        cycle(0, '0, 0, '0, 1);
        idle(4);

        // Reset with three ops in flight.
        do_reset();
        idle(3);
        cycle(1, 17'h00111, 1, 17'h00222, 0);
        cycle(1, 17'h00333, 1, 17'h00444, 0);
        cycle(1, 17'h00555, 0, '0, 0);
        cycle(0, '0, 0, '0, 0);
        do_reset();
        idle(10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
